inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 113 +++++++++++
 tb/tb_inst_fetch.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: one outstanding imem read, hold-until-consumed, sticky faults
//
// Ports:
//   clk          in   clock, rising edge
//   rst_         in   asynchronous active-low reset
//   next_pc_in   in   [31:0] next address from the next-PC mux, taken when an instruction is consumed
//   pc           out  [31:0] address of the instruction being fetched or held
//   pc_plus4     out  [31:0] pc + 4 (combinational)
//   imem_req     out  instruction-memory read request
//   imem_addr    out  [31:0] read address (always pc)
//   imem_ack     in   read data valid
//   imem_rdata   in   [31:0] read data
//   inst         out  [31:0] captured instruction
//   inst_valid   out  inst/pc valid for the downstream stage
//   inst_ready   in   downstream consumes inst this cycle
//   fault        out  [1:0] sticky fault: 00 none, 01 misaligned next pc, 10 fetch timeout
//   fetch_count  out  [31:0] instructions consumed, wrapping
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic [31:0] next_pc_in,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [1:0]  fault,
    output logic [31:0] fetch_count
);

    localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WW-1:0] LAST_WAIT = WW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        VALID = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t        state;
    logic [WW-1:0] wait_cnt;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;

    // imem_req is a register rather than a decode of FETCH so that it reads 0
    // throughout reset and first rises on the first edge after reset releases.
    // While in FETCH with imem_req still 0 no ack is honoured.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            inst        <= 32'd0;
            fault       <= 2'b00;
            fetch_count <= 32'd0;
            wait_cnt    <= '0;
            imem_req    <= 1'b0;
            inst_valid  <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        // An ack on the last allowed cycle still wins over the timeout.
                        inst       <= imem_rdata;
                        wait_cnt   <= '0;
                        imem_req   <= 1'b0;
                        inst_valid <= 1'b1;
                        state      <= VALID;
                    end else if (wait_cnt == LAST_WAIT) begin
                        fault    <= 2'b10;
                        imem_req <= 1'b0;
                        state    <= HALT;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                VALID: begin
                    if (inst_ready) begin
                        fetch_count <= fetch_count + 32'd1;
                        inst_valid  <= 1'b0;
                        if (next_pc_in[1:0] == 2'b00) begin
                            pc       <= next_pc_in;
                            imem_req <= 1'b1;
                            state    <= FETCH;
                        end else begin
                            fault <= 2'b01;
                            state <= HALT;
                        end
                    end
                end
                HALT: begin
                    imem_req   <= 1'b0;
                    inst_valid <= 1'b0;
                end
                default: begin
                    imem_req   <= 1'b0;
                    inst_valid <= 1'b0;
                    state      <= HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - randomized and directed checks of inst_fetch against a behavioural model
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          MAX_WAIT = 16;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic [31:0] next_pc_in = 32'd0;
    logic [31:0] pc, pc_plus4, imem_addr, inst, fetch_count;
    logic        imem_req, inst_valid;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        inst_ready = 1'b0;
    logic [1:0]  fault;

    int n_checks = 0;
    int n_fail   = 0;

    inst_fetch #(.RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_(rst_), .next_pc_in(next_pc_in),
        .pc(pc), .pc_plus4(pc_plus4),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .fault(fault), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Behavioural view: one outstanding read; a read is "live" once requested,
    // an instruction is "held" once captured; any nonzero fault means stopped.
    logic [31:0] m_pc, m_inst, m_cnt;
    logic        m_req, m_valid;
    logic [1:0]  m_fault;
    int          m_waited;

    function automatic void model_reset();
        m_pc = RESET_PC; m_inst = 32'd0; m_cnt = 32'd0;
        m_req = 1'b0; m_valid = 1'b0; m_fault = 2'b00; m_waited = 0;
    endfunction

    function automatic void model_edge();
        if (m_fault != 2'b00) return;
        if (m_req) begin
            if (imem_ack) begin
                m_inst = imem_rdata; m_valid = 1'b1; m_req = 1'b0; m_waited = 0;
            end else if (m_waited + 1 >= MAX_WAIT) begin
                m_fault = 2'b10; m_req = 1'b0;
            end else begin
                m_waited++;
            end
        end else if (m_valid) begin
            if (inst_ready) begin
                m_cnt++;
                m_valid = 1'b0;
                if (next_pc_in % 4 == 0) begin
                    m_pc = next_pc_in; m_req = 1'b1;
                end else begin
                    m_fault = 2'b01;
                end
            end
        end else begin
            m_req = 1'b1;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("imem_req", 32'(imem_req), 32'(m_req));
        chk("imem_addr", imem_addr, m_pc);
        chk("inst", inst, m_inst);
        chk("inst_valid", 32'(inst_valid), 32'(m_valid));
        chk("fault", 32'(fault), 32'(m_fault));
        chk("fetch_count", fetch_count, m_cnt);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_) model_edge();
        @(negedge clk);
        compare_all();
    endtask

    // Assert reset partway through a cycle and check the outputs clear with no clock edge.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_ = 1'b0;
        imem_ack = 1'b1;
        #1;
        model_reset();
        chk("rst_async_pc", pc, RESET_PC);
        chk("rst_async_valid", 32'(inst_valid), 32'd0);
        chk("rst_async_count", fetch_count, 32'd0);
        chk("rst_async_req", 32'(imem_req), 32'd0);
        chk("rst_async_fault", 32'(fault), 32'd0);
        repeat (2) step();
        rst_ = 1'b1;
        imem_ack = 1'b0;
    endtask

    initial begin
        logic [31:0] seen [4];
        int k;
        int stall;
        logic [31:0] r;

        model_reset();
        do_reset();

        // Zero-wait sequential stream.
        imem_ack = 1'b1; imem_rdata = 32'h2001_0005; inst_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 9; c++) begin
            next_pc_in = m_pc + 32'd4;
            step();
            if (inst_valid && k < 4) begin seen[k] = pc; k++; end
        end
        chk("seq_valid_count", 32'(k), 32'd4);
        chk("seq_pc0", seen[0], 32'h0);
        chk("seq_pc1", seen[1], 32'h4);
        chk("seq_pc2", seen[2], 32'h8);
        chk("seq_pc3", seen[3], 32'hC);
        chk("seq_fetch_count", fetch_count, 32'd4);
        chk("seq_inst", inst, 32'h2001_0005);

        // Branch redirect from 0x10 to 0x40.
        next_pc_in = m_pc + 32'd4;
        step();
        chk("br_pc_before", pc, 32'h10);
        next_pc_in = 32'h40;
        step();
        chk("br_addr", imem_addr, 32'h40);
        chk("br_pc_plus4", pc_plus4, 32'h44);
        chk("br_req", 32'(imem_req), 32'd1);

        // Backpressure on the instruction at 0x40.
        step();
        inst_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp_pc", pc, 32'h40);
            chk("bp_inst", inst, 32'h2001_0005);
            chk("bp_req", 32'(imem_req), 32'd0);
            chk("bp_count", fetch_count, 32'd5);
        end

        // Consume with a misaligned target: counts once, then halts.
        inst_ready = 1'b1;
        next_pc_in = 32'h42;
        step();
        chk("mis_fault", 32'(fault), 32'h1);
        chk("mis_count", fetch_count, 32'd6);
        for (int c = 0; c < 20; c++) begin
            step();
            chk("mis_pc", pc, 32'h40);
            chk("mis_req", 32'(imem_req), 32'd0);
        end
        do_reset();
        chk("mis_reset_fault", 32'(fault), 32'd0);

        // Timeout after MAX_WAIT request cycles without ack.
        imem_ack = 1'b0;
        repeat (MAX_WAIT) step();
        chk("to_fault_before", 32'(fault), 32'd0);
        step();
        chk("to_fault", 32'(fault), 32'h2);
        chk("to_req", 32'(imem_req), 32'd0);

        // Ack on the last allowed cycle is a normal capture.
        do_reset();
        imem_ack = 1'b0;
        imem_rdata = 32'h1234_5678;
        repeat (MAX_WAIT) step();
        imem_ack = 1'b1;
        step();
        chk("late_ack_fault", 32'(fault), 32'd0);
        chk("late_ack_valid", 32'(inst_valid), 32'd1);
        chk("late_ack_inst", inst, 32'h1234_5678);

        // Reach fetch_count=7 with an instruction held, then reset mid-cycle.
        do_reset();
        imem_ack = 1'b1; inst_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (fetch_count == 32'd7 && inst_valid) break;
            next_pc_in = m_pc + 32'd4;
            step();
        end
        chk("ar_count_before", fetch_count, 32'd7);
        chk("ar_valid_before", 32'(inst_valid), 32'd1);
        do_reset();

        // Randomized traffic.
        stall = 0;
        for (int c = 0; c < 4000; c++) begin
            if ((m_fault != 2'b00 && $urandom_range(9) == 0) || $urandom_range(799) == 0) begin
                do_reset();
            end
            if (stall == 0 && $urandom_range(249) == 0) stall = $urandom_range(24, 10);
            if (stall > 0) begin
                imem_ack = 1'b0;
                stall--;
            end else begin
                imem_ack = ($urandom_range(3) != 0);
            end
            imem_rdata = $urandom();
            inst_ready = ($urandom_range(2) != 0);
            r = $urandom();
            case ($urandom_range(99)) inside
                [0:1]:   next_pc_in = {r[31:2], 2'b00} | 32'(($urandom_range(2)) + 1);
                [2:14]:  next_pc_in = {r[31:2], 2'b00};
                default: next_pc_in = m_pc + 32'd4;
            endcase
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
